// File: rtl/sll_iter_if.sv
// Operand/result bundle for the iterative left shifter.
interface sll_iter_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;
  logic        carry;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b,
    input  out, carry, busy, done
  );

  modport slave (
    input  start, a, b,
    output out, carry, busy, done
  );
endinterface

// File: rtl/sll_iter.sv
// Iterative 32-bit logical shift left, up to BITS_PER_CYCLE positions per cycle.
module sll_iter #(
  parameter int unsigned BITS_PER_CYCLE = 1  // 1, 2 or 4
) (
  input  logic       clk,
  input  logic       rst_n,
  sll_iter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [4:0] Step = 5'(BITS_PER_CYCLE);

  state_e      state_q, state_d;
  logic [31:0] out_q, out_d;
  logic        carry_q, carry_d;
  logic [4:0]  count_q, count_d;

  logic [4:0]  step;
  logic [32:0] shifted;

  // Upper bits of b carry no meaning for the shift amount.
  logic unused_b;
  assign unused_b = ^bus.b[31:5];

  // Shift datapath: bit 32 of the widened result is the last bit pushed out of bit 31.
  always_comb begin
    step    = (count_q < Step) ? count_q : Step;
    shifted = {1'b0, out_q} << step;
  end

  // Next-state logic: accept in idle/done, iterate while shifting.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    count_d = count_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          out_d   = bus.a;
          count_d = bus.b[4:0];
          carry_d = 1'b0;
          state_d = (bus.b[4:0] != 5'd0) ? StShift : StDone;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StShift: begin
        // step never exceeds count, so count cannot wrap.
        out_d   = shifted[31:0];
        carry_d = shifted[32];
        count_d = count_q - step;
        state_d = (count_q == step) ? StDone : StShift;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      out_q   <= 32'd0;
      carry_q <= 1'b0;
      count_q <= 5'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.carry = carry_q;
  assign bus.busy  = (state_q == StShift);
  assign bus.done  = (state_q == StDone);

endmodule

// File: tb/tb_sll_iter.sv
// Scoreboard bench for sll_iter: one instance per shift rate (1 and 4 bits/cycle).
module tb_sll_iter;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] out;
    logic        carry;
    int unsigned due;
    int unsigned k;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  sll_iter_if bus1 ();
  sll_iter_if bus4 ();

  sll_iter #(.BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  sll_iter #(.BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic drive(input int u, input logic st, input logic [31:0] av, input logic [31:0] bv);
    if (u == 4) begin
      bus4.start = st; bus4.a = av; bus4.b = bv;
    end else begin
      bus1.start = st; bus1.a = av; bus1.b = bv;
    end
  endtask

  // Done is expected k+1 cycles after the negedge that presents start.
  task automatic push(input int u, input logic [31:0] eo, input logic ec, input int unsigned k,
                      input int unsigned c);
    exp_t e;
    e.out = eo; e.carry = ec; e.k = k; e.due = c + k + 1;
    if (u == 4) q4.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic op(input int u, input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] eo, input logic ec, input int unsigned k);
    @(negedge clk);
    push(u, eo, ec, k, cyc);
    drive(u, 1'b1, av, bv);
    @(negedge clk);
    drive(u, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic op_nopush(input int u, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    drive(u, 1'b1, av, bv);
    @(negedge clk);
    drive(u, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q4.size() == 0) break;
    end
    if (q1.size() != 0 || q4.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q1.size(), q4.size());
      q1.delete();
      q4.delete();
    end
  endtask

  // Monitor for the 1-bit/cycle instance.
  initial begin
    int unsigned bc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0;
      end else begin
        if (bus1.busy) bc++;
        if (bus1.done) begin
          if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u1_spurious_done actual=1 required=0 at cycle %0d", cyc);
          end else begin
            e = q1.pop_front();
            check("u1_out", bus1.out, e.out);
            check("u1_carry", {31'd0, bus1.carry}, {31'd0, e.carry});
            check("u1_latency", cyc, e.due);
            check("u1_busy_cycles", bc, e.k);
          end
          bc = 0;
        end
      end
    end
  end

  // Monitor for the 4-bit/cycle instance.
  initial begin
    int unsigned bc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0;
      end else begin
        if (bus4.busy) bc++;
        if (bus4.done) begin
          if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u4_spurious_done actual=1 required=0 at cycle %0d", cyc);
          end else begin
            e = q4.pop_front();
            check("u4_out", bus4.out, e.out);
            check("u4_carry", {31'd0, bus4.carry}, {31'd0, e.carry});
            check("u4_latency", cyc, e.due);
            check("u4_busy_cycles", bc, e.k);
          end
          bc = 0;
        end
      end
    end
  end

  initial begin
    int unsigned c0;
    rst_n = 1'b0;
    drive(1, 1'b0, 32'd0, 32'd0);
    drive(4, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("rst_out", bus1.out, 32'd0);
    check("rst_carry", {31'd0, bus1.carry}, 32'd0);
    check("rst_busy", {31'd0, bus1.busy}, 32'd0);
    check("rst_done", {31'd0, bus4.done}, 32'd0);
    rst_n = 1'b1;

    // 1 bit per cycle
    op(1, 32'h0000_0001, 32'd4, 32'h0000_0010, 1'b0, 4);
    drain();
    op(1, 32'hC000_0003, 32'h0000_0021, 32'h8000_0006, 1'b1, 1);
    drain();
    op(1, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 0);
    drain();
    op(1, 32'h0000_0005, 32'd31, 32'h8000_0000, 1'b0, 31);
    drain();
    op(1, 32'h0000_0003, 32'd31, 32'h8000_0000, 1'b1, 31);
    drain();

    // Start during SHIFT is dropped.
    op(1, 32'h0000_0001, 32'd8, 32'h0000_0100, 1'b0, 8);
    op_nopush(1, 32'hFFFF_FFFF, 32'd3);
    drain();

    // Back-to-back starts accepted in DONE: n=0, n=0 (upper b bits set), then n=2.
    @(negedge clk);
    c0 = cyc;
    drive(1, 1'b1, 32'h0000_0007, 32'd0);
    push(1, 32'h0000_0007, 1'b0, 0, c0);
    @(negedge clk);
    drive(1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0020);
    push(1, 32'hDEAD_BEEF, 1'b0, 0, c0 + 1);
    @(negedge clk);
    drive(1, 1'b1, 32'h0000_0003, 32'd2);
    push(1, 32'h0000_000C, 1'b0, 2, c0 + 2);
    @(negedge clk);
    drive(1, 1'b0, 32'd0, 32'd0);
    drain();

    // 4 bits per cycle
    op(4, 32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 1'b1, 8);
    drain();
    op(4, 32'h0800_0001, 32'd5, 32'h0000_0020, 1'b1, 2);
    drain();
    op(4, 32'h1000_0003, 32'd4, 32'h0000_0030, 1'b1, 1);
    drain();
    op(4, 32'h0000_0001, 32'hFFFF_FFE3, 32'h0000_0008, 1'b0, 1);
    drain();

    // Reset two cycles into a 10-bit shift aborts it with no done pulse.
    op_nopush(1, 32'h0000_0001, 32'd10);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out", bus1.out, 32'd0);
    check("abort_carry", {31'd0, bus1.carry}, 32'd0);
    check("abort_busy", {31'd0, bus1.busy}, 32'd0);
    check("abort_done", {31'd0, bus1.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_done", {31'd0, bus1.done}, 32'd0);
    end
    op(1, 32'hF0F0_F0F0, 32'd4, 32'h0F0F_0F00, 1'b1, 4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
